// File: rtl/ysyx_22040088_ifq.sv
// ysyx_22040088_ifq -- instruction fetch queue between fetch and decode.
// Circular buffer of DEPTH entries {pc, inst, jump, misalign}.
// Optional feature macro: YSYX_22040088_IFQ_BYPASS_EN. When it is defined,
// an empty queue hands the presented instruction straight through to decode
// in the same cycle, provided decode is ready.
module ysyx_22040088_ifq #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [63:0]                in_pc,
  input  logic [31:0]                in_inst,
  input  logic                       in_jump,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [63:0]                out_pc,
  output logic [31:0]                out_inst,
  output logic                       out_jump,
  output logic                       out_misalign,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        jump;
    logic        misalign;
  } ent_t;

  ent_t            mem_q [DEPTH];
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  ent_t            in_ent, head_ent;
  logic            byp, push, pop;

  assign in_ent   = '{pc: in_pc, inst: in_inst, jump: in_jump,
                      misalign: (in_pc[1:0] != 2'b00)};
  assign head_ent = mem_q[head_q];

`ifdef YSYX_22040088_IFQ_BYPASS_EN
  // Empty queue and decode ready: hand the instruction over without storing it.
  assign byp = !rst && (count_q == '0) && in_valid && out_ready && !flush;
`else
  assign byp = 1'b0;
`endif

  // Occupancy is reported as zero for the whole reset cycle, not one edge later.
  assign count     = rst ? '0 : count_q;
  assign in_ready  = !rst && (count_q < CW'(DEPTH));
  assign out_valid = byp || (!rst && (count_q != '0) && !flush);

  // Head entry, or the incoming one while bypassing.
  always_comb begin
    out_pc       = head_ent.pc;
    out_inst     = head_ent.inst;
    out_jump     = head_ent.jump;
    out_misalign = head_ent.misalign;
    if (byp) begin
      out_pc       = in_ent.pc;
      out_inst     = in_ent.inst;
      out_jump     = in_ent.jump;
      out_misalign = in_ent.misalign;
    end
  end

  // A bypassed instruction is neither pushed nor popped.
  assign push = in_valid && in_ready && !flush && !byp;
  assign pop  = out_valid && out_ready && !byp;

  // Next pointers and occupancy. A flush wins over any concurrent push or pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + 1'b1;
      if (push) tail_d = tail_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // Control state. Reset has priority over flush, push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is deliberately not reset. push is already blocked during rst.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= in_ent;
  end
endmodule

// File: tb/tb_ysyx_22040088_ifq.sv
// tb_ysyx_22040088_ifq -- directed scenarios followed by random traffic.
// The outputs are checked every cycle against a queue-based reference model.
module tb_ysyx_22040088_ifq;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        jump;
    logic        mis;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [63:0]   in_pc = '0;
  logic [31:0]   in_inst = '0;
  logic          in_jump = 1'b0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic          out_valid;
  logic [63:0]   out_pc;
  logic [31:0]   out_inst;
  logic          out_jump;
  logic          out_misalign;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;

  int   n_chk  = 0;
  int   n_fail = 0;
  ent_t mq[$];

  ysyx_22040088_ifq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc),
    .in_inst(in_inst), .in_jump(in_jump), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_pc(out_pc),
    .out_inst(out_inst), .out_jump(out_jump), .out_misalign(out_misalign),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check the DUT against the
  // model, then advance the model to reflect the coming rising edge.
  task automatic step(input bit r, input bit iv, input logic [63:0] pc,
                      input logic [31:0] ins, input bit j, input bit fl,
                      input bit ordy);
    ent_t e;
    bit   byp, exp_ov, exp_ir;
    @(negedge clk);
    rst = r; in_valid = iv; in_pc = pc; in_inst = ins; in_jump = j;
    flush = fl; out_ready = ordy;
    #1;
    exp_ir = !r && (mq.size() < DEPTH);
    byp = 1'b0;
`ifdef YSYX_22040088_IFQ_BYPASS_EN
    byp = !r && (mq.size() == 0) && iv && ordy && !fl;
`endif
    exp_ov = byp || (!r && (mq.size() != 0) && !fl);
    chk("in_ready",  64'(in_ready),  64'(exp_ir));
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    chk("count",     64'(count),     r ? 64'd0 : 64'(mq.size()));
    if (exp_ov && out_valid) begin
      if (byp) e = '{pc, ins, j, (pc[1:0] != 2'b00)};
      else     e = mq[0];
      chk("out_pc",       out_pc,              e.pc);
      chk("out_inst",     64'(out_inst),       64'(e.inst));
      chk("out_jump",     64'(out_jump),       64'(e.jump));
      chk("out_misalign", 64'(out_misalign),   64'(e.mis));
    end
    if (r || fl) mq.delete();
    else begin
      if (exp_ov && ordy && !byp) void'(mq.pop_front());
      if (iv && exp_ir && !byp)   mq.push_back('{pc, ins, j, (pc[1:0] != 2'b00)});
    end
  endtask

  // Check occupancy and output status after the last stepped edge.
  task automatic peek(input string tag, input int exp_cnt, input bit exp_ov);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; rst = 1'b0;
    #1;
    chk({tag, "_count"}, 64'(count), 64'(exp_cnt));
    chk({tag, "_ov"},    64'(out_valid), 64'(exp_ov));
  endtask

  initial begin
    logic [63:0] pc;
    // reset state
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 64'h1000, 32'h13, 0, 0, 1);
    // four pushes fill the queue; the fifth is refused
    for (int i = 0; i < 4; i++)
      step(0, 1, 64'h8000_0000 + 64'(4*i), 32'h100 + 32'(i), 0, 0, 0);
    step(0, 1, 64'h8000_0010, 32'hdead, 0, 0, 0);
    peek("full", 4, 1);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    // drain in order
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1);
    peek("drained", 0, 0);
    // keep two in flight through repeated pointer wrap
    step(0, 1, 64'h8000_1000, 32'h1, 0, 0, 0);
    step(0, 1, 64'h8000_1004, 32'h2, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      step(0, 1, 64'h8000_1008 + 64'(4*i), 32'h10 + 32'(i), 0, 0, 1);
    peek("wrap", 2, 1);
    // flush with three queued and one presented
    step(0, 1, 64'h8000_2000, 32'h3, 0, 0, 0);
    peek("pre_flush", 3, 1);
    step(0, 1, 64'h8000_2004, 32'h4, 0, 1, 1);
    peek("flush", 0, 0);
    // misaligned jump target
    step(0, 1, 64'h8000_0002, 32'h6f, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    // empty queue, valid and ready together
    step(0, 1, 64'h8000_3000, 32'h77, 0, 0, 1);
`ifdef YSYX_22040088_IFQ_BYPASS_EN
    peek("bypass", 0, 0);
`else
    peek("latency", 1, 1);
`endif
    step(0, 0, 0, 0, 0, 0, 1);
    // reset mid-operation, then ready on the first free cycle
    step(0, 1, 64'h8000_4000, 32'h5, 0, 0, 0);
    step(1, 1, 64'h8000_4004, 32'h6, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      pc = {32'h8000_0000, $urandom()};
      if ($urandom_range(0, 7) != 0) pc[1:0] = 2'b00;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), pc,
           $urandom(), $urandom_range(0, 1) == 1, ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 6));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_22040088_ifq.md
YSYX_22040088_IFQ -- requirements
Module: ysyx_22040088_ifq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; power of two, 2..16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  fetch stage presents an instruction.
REQ-005 SHALL have port in_pc  input  64  PC of presented instruction.
REQ-006 SHALL have port in_inst  input  32  presented instruction word.
REQ-007 SHALL have port in_jump  input  1  fetch stage already redirected on this instruction (JAL predecode).
REQ-008 SHALL have port in_ready  output  1  queue accepts an entry this cycle.
REQ-009 SHALL have port flush  input  1  branch redirect from execute; discard all queued and incoming entries.
REQ-010 SHALL have port out_valid  output  1  head entry valid to decode.
REQ-011 SHALL have port out_pc  output  64  head entry PC.
REQ-012 SHALL have port out_inst  output  32  head entry instruction.
REQ-013 SHALL have port out_jump  output  1  head entry jump flag.
REQ-014 SHALL have port out_misalign  output  1  head entry PC with in_pc[1:0] != 0 at push time.
REQ-015 SHALL have port out_ready  input  1  decode consumes head entry this cycle.
REQ-016 SHALL have port count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-017 SHALL push {in_pc, in_inst, in_jump, in_pc[1:0]!=0} at tail when in_valid && in_ready && !flush.
REQ-018 SHALL pop head when out_valid && out_ready.
REQ-019 SHALL drive in_ready = !rst && (count < DEPTH); a full queue SHALL NOT accept a push in the same cycle as a pop.
REQ-020 SHALL drive out_valid = (count != 0) && !flush (except REQ-030); out_* SHALL be combinational from the head entry.
REQ-021 SHALL preserve FIFO order; head/tail pointers SHALL wrap modulo DEPTH with no lost or duplicated entries.
REQ-022 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged.
REQ-023 flush SHALL, in the same edge, set count=0 and head=tail=0, discarding any concurrent push and pop.
REQ-024 Latency in_valid accept to out_valid SHALL be exactly 1 cycle when the queue was empty (without REQ-030).
REQ-025 out_* data while out_valid=0 SHALL be don't-care; the bench SHALL NOT check it.
REQ-026 out_* SHALL hold stable while out_valid && !out_ready, absent flush.

Reset
REQ-027 While rst=1: count=0, head=tail=0, out_valid=0, in_ready=0; entry storage SHALL NOT be reset.
REQ-028 Reset asserted mid-operation SHALL discard all entries on the next edge; in_ready=1 in the first cycle after rst deasserts.
REQ-029 rst SHALL take priority over flush, push and pop.

Configuration
REQ-030 With YSYX_22040088_IFQ_BYPASS_EN defined: when count=0, in_valid=1, out_ready=1 and !flush, out_* SHALL equal in_* combinationally, out_valid=1, and the entry SHALL NOT be stored (zero-latency pass-through); count SHALL stay 0.
REQ-031 Without YSYX_22040088_IFQ_BYPASS_EN: no combinational in_* to out_* path SHALL exist; REQ-024 latency applies.

Verification
REQ-032 Reset then push pc 0x80000000, 0x80000004, 0x80000008, 0x8000000C with out_ready=0 -> count=4, in_ready=0; fifth push ignored.
REQ-033 From REQ-032 state raise out_ready for 4 cycles -> out_pc 0x80000000, ..04, ..08, ..0C in order; count=0, out_valid=0.
REQ-034 count=2, push and pop every cycle for 20 cycles (pointer wrap) -> count stays 2, out_pc strictly in push order.
REQ-035 count=3, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, flushed PC never appears at output.
REQ-036 Push in_pc 0x80000002, in_jump=1 -> out_misalign=1, out_jump=1 on that entry.
REQ-037 Empty queue, in_valid=1, out_ready=1: with BYPASS_EN out_valid=1 same cycle and count=0; without, out_valid=0 then 1 next cycle.
